// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite renderer: coordinate/delta types,
// index-width helper and the saturating position update used on frame_tick.
package sprite_pkg;

   localparam int COORD_W = 11;

   typedef logic [COORD_W-1:0]      coord_t;
   typedef logic signed [3:0]       delta_t;
   typedef logic signed [COORD_W:0] sum_t;

   // Width of an index over n items; never below 1 so degenerate sizes still elaborate.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic sum_t move_sum(input coord_t pos, input delta_t d);
      return $signed({1'b0, pos}) + $signed({{(COORD_W - 3){d[3]}}, d});
   endfunction

   function automatic coord_t clamp_coord(input sum_t sum, input coord_t max);
      if (sum < 0) begin
         return '0;
      end else if (sum > $signed({1'b0, max})) begin
         return max;
      end else begin
         return sum[COORD_W-1:0];
      end
   endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous sprite ROM: one SPR_W-bit row per address {frame,row}, data valid the
// cycle after addr. Contents are a fixed built-in pattern: bit i of word a is opaque when (a+i)%3 != 0.
module sprite_rom
   import sprite_pkg::*;
#(
   parameter int SPR_W    = 32,
   parameter int SPR_H    = 16,
   parameter int N_FRAMES = 4,
   localparam int ADDR_W  = idx_w(N_FRAMES) + idx_w(SPR_H)
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [SPR_W-1:0]  data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [SPR_W-1:0] mem [DEPTH];
   logic [SPR_W-1:0] data_q;

   for (genvar a = 0; a < DEPTH; a++) begin : g_word
      for (genvar i = 0; i < SPR_W; i++) begin : g_bit
         assign mem[a][i] = (((a + i) % 3) != 0);
      end
   end

   always_ff @(posedge clk) begin
      data_q <= mem[addr];
   end

   assign data = data_q;

endmodule

// File: rtl/sprite_engine.sv
// Movable, animated, scalable and mirrorable sprite: position/animation registers plus a
// two-stage pixel pipeline (box test + ROM fetch, then bit select) producing a registered paint flag.
module sprite_engine
   import sprite_pkg::*;
#(
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 16,
   parameter int N_FRAMES   = 4,
   parameter int SCALE_LOG2 = 0,
   parameter int ANIM_DIV   = 8,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int INIT_X     = 0,
   parameter int INIT_Y     = 0,
   localparam int FR_W      = idx_w(N_FRAMES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic [COORD_W-1:0]       pix_x,
   input  logic [COORD_W-1:0]       pix_y,
   input  logic                     enable,
   input  logic signed [3:0]        dx,
   input  logic signed [3:0]        dy,
   input  logic                     mirror,
   output logic [COORD_W-1:0]       pos_x,
   output logic [COORD_W-1:0]       pos_y,
   output logic [FR_W-1:0]          frame_idx,
   output logic                     paint
);

   localparam int ROW_W  = idx_w(SPR_H);
   localparam int COL_W  = idx_w(SPR_W);
   localparam int ANIM_W = idx_w(ANIM_DIV);
   localparam int ADDR_W = FR_W + ROW_W;
   localparam int EW     = SPR_W << SCALE_LOG2;
   localparam int EH     = SPR_H << SCALE_LOG2;

   localparam coord_t XMAX = coord_t'(H_RES - EW);
   localparam coord_t YMAX = coord_t'(V_RES - EH);
   localparam coord_t X0   = coord_t'(INIT_X);
   localparam coord_t Y0   = coord_t'(INIT_Y);

   localparam logic [COORD_W:0]  EW_W      = (COORD_W + 1)'(EW);
   localparam logic [COORD_W:0]  EH_W      = (COORD_W + 1)'(EH);
   localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
   localparam logic [FR_W-1:0]   FR_LAST   = FR_W'(N_FRAMES - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SPR_W - 1);

   coord_t            pos_x_q, pos_x_d;
   coord_t            pos_y_q, pos_y_d;
   logic [FR_W-1:0]   frame_q, frame_d;
   logic [ANIM_W-1:0] anim_q, anim_d;

   logic              valid1_q;
   logic              hit1_q, hit1_d;
   logic [COL_W-1:0]  col1_q, col1_d;
   logic              mirror1_q;
   logic              paint_q, paint_d;

   logic [COORD_W:0]  px_w, py_w, x0_w, y0_w;
   coord_t            off_x, off_y;
   logic [ROW_W-1:0]  row_s1;
   logic [ADDR_W-1:0] rom_addr;
   logic [SPR_W-1:0]  rom_data;
   logic [COL_W-1:0]  bit_idx;

   // Movement and animation only advance on an enabled frame_tick.
   always_comb begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      frame_d = frame_q;
      anim_d  = anim_q;
      if (frame_tick && enable) begin
         pos_x_d = clamp_coord(move_sum(pos_x_q, dx), XMAX);
         pos_y_d = clamp_coord(move_sum(pos_y_q, dy), YMAX);
         if (anim_q == ANIM_LAST) begin
            anim_d  = '0;
            frame_d = (frame_q == FR_LAST) ? '0 : frame_q + 1'b1;
         end else begin
            anim_d  = anim_q + 1'b1;
         end
      end
   end

   // Stage 1: box test in 12 bits so pos+extent cannot wrap; address the ROM row.
   always_comb begin
      px_w     = {1'b0, pix_x};
      py_w     = {1'b0, pix_y};
      x0_w     = {1'b0, pos_x_q};
      y0_w     = {1'b0, pos_y_q};
      hit1_d   = (px_w >= x0_w) && (px_w < x0_w + EW_W) &&
                 (py_w >= y0_w) && (py_w < y0_w + EH_W);
      off_x    = pix_x - pos_x_q;
      off_y    = pix_y - pos_y_q;
      col1_d   = COL_W'(off_x >> SCALE_LOG2);
      row_s1   = ROW_W'(off_y >> SCALE_LOG2);
      rom_addr = {frame_q, (hit1_d ? row_s1 : {ROW_W{1'b0}})};
   end

   sprite_rom #(
      .SPR_W    (SPR_W),
      .SPR_H    (SPR_H),
      .N_FRAMES (N_FRAMES)
   ) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   // Stage 2: MSB of a ROM word is the leftmost pixel, so unmirrored reads count down.
   always_comb begin
      bit_idx = mirror1_q ? col1_q : COL_LAST - col1_q;
      paint_d = valid1_q & hit1_q & rom_data[bit_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x_q   <= X0;
         pos_y_q   <= Y0;
         frame_q   <= '0;
         anim_q    <= '0;
         valid1_q  <= 1'b0;
         hit1_q    <= 1'b0;
         col1_q    <= '0;
         mirror1_q <= 1'b0;
         paint_q   <= 1'b0;
      end else begin
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         frame_q   <= frame_d;
         anim_q    <= anim_d;
         valid1_q  <= 1'b1;
         hit1_q    <= hit1_d;
         col1_q    <= col1_d;
         mirror1_q <= mirror;
         paint_q   <= paint_d;
      end
   end

   assign pos_x     = pos_x_q;
   assign pos_y     = pos_y_q;
   assign frame_idx = frame_q;
   assign paint     = paint_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: one unscaled instance at (100,50) and one 2x-scaled instance at (0,0).
module tb_sprite_engine;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic [10:0] pix_x, pix_y;
   logic        enable;
   logic signed [3:0] dx, dy;
   logic        mirror;
   logic [10:0] pos_x, pos_y;
   logic [1:0]  frame_idx;
   logic        paint;

   logic        b_tick, b_enable, b_mirror;
   logic signed [3:0] b_dx, b_dy;
   logic [10:0] b_pix_x, b_pix_y;
   logic [10:0] b_pos_x, b_pos_y;
   logic [1:0]  b_frame_idx;
   logic        b_paint;

   int checks;
   int errors;
   int m_cnt;
   int m_frame;
   logic exp_q[$];

   sprite_engine #(
      .SPR_W(32), .SPR_H(16), .N_FRAMES(4), .SCALE_LOG2(0), .ANIM_DIV(8),
      .H_RES(640), .V_RES(480), .INIT_X(100), .INIT_Y(50)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
      .enable(enable), .dx(dx), .dy(dy), .mirror(mirror),
      .pos_x(pos_x), .pos_y(pos_y), .frame_idx(frame_idx), .paint(paint)
   );

   sprite_engine #(
      .SPR_W(32), .SPR_H(16), .N_FRAMES(4), .SCALE_LOG2(1), .ANIM_DIV(8),
      .H_RES(640), .V_RES(480), .INIT_X(0), .INIT_Y(0)
   ) dut_b (
      .clk(clk), .rst(rst), .frame_tick(b_tick), .pix_x(b_pix_x), .pix_y(b_pix_y),
      .enable(b_enable), .dx(b_dx), .dy(b_dy), .mirror(b_mirror),
      .pos_x(b_pos_x), .pos_y(b_pos_y), .frame_idx(b_frame_idx), .paint(b_paint)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic logic rom_bit(input int a, input int i);
      return ((a + i) % 3) != 0;
   endfunction

   function automatic logic exp_paint(input int px, input int py, input int posx, input int posy,
                                      input int frame, input int mir, input int s);
      int col, row, idx;
      if (px >= posx && px < posx + (32 << s) && py >= posy && py < posy + (16 << s)) begin
         col = (px - posx) >> s;
         row = (py - posy) >> s;
         idx = (mir != 0) ? col : 31 - col;
         return rom_bit(frame * 16 + row, idx);
      end
      return 1'b0;
   endfunction

   // ---------------- drivers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      m_cnt = 0;
      m_frame = 0;
   endtask

   task automatic tick(input logic en, input int ddx, input int ddy);
      enable = en;
      dx = 4'(ddx);
      dy = 4'(ddy);
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
      if (en) begin
         m_cnt++;
         if (m_cnt == 8) begin
            m_cnt = 0;
            m_frame = (m_frame + 1) % 4;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      pix_x = 11'd0;
      pix_y = 11'd0;
      rst = 1'b1;
      cycle();
      cycle();
      cycle();
      checks++;
      if (paint !== 1'b0) begin errors++; $display("FAIL reset_paint got %0d exp 0", paint); end
      checks++;
      if (pos_x !== 11'd100 || pos_y !== 11'd50) begin
         errors++; $display("FAIL reset_pos got (%0d,%0d) exp (100,50)", pos_x, pos_y);
      end
      checks++;
      if (frame_idx !== 2'd0) begin errors++; $display("FAIL reset_frame got %0d exp 0", frame_idx); end
      checks++;
      if (b_pos_x !== 11'd0 || b_pos_y !== 11'd0) begin
         errors++; $display("FAIL reset_pos_b got (%0d,%0d) exp (0,0)", b_pos_x, b_pos_y);
      end
      rst = 1'b0;
      m_cnt = 0;
      m_frame = 0;
      pix_x = 11'd100;
      pix_y = 11'd50;
      cycle();
      checks++;
      if (paint !== 1'b0) begin errors++; $display("FAIL latency1_paint got %0d exp 0", paint); end
      cycle();
      checks++;
      if (paint !== 1'b1) begin errors++; $display("FAIL first_pixel_paint got %0d exp 1", paint); end
   endtask

   task automatic test_stream();
      logic e;
      exp_q.delete();
      for (int k = 0; k <= 44; k++) begin
         if (k < 44) begin
            pix_x = 11'(94 + k);
            pix_y = 11'd51;
            mirror = (k % 3 == 0);
            exp_q.push_back(exp_paint(94 + k, 51, 100, 50, 0, (k % 3 == 0) ? 1 : 0, 0));
         end
         cycle();
         if (k >= 1) begin
            e = exp_q.pop_front();
            checks++;
            if (paint !== e) begin
               errors++; $display("FAIL stream_paint x=%0d got %0d exp %0d", 94 + k - 1, paint, e);
            end
         end
      end
      mirror = 1'b0;
   endtask

   task automatic test_animation();
      for (int t = 1; t <= 40; t++) begin
         tick(1'b1, 0, 0);
         if (t == 7 || t == 8 || t == 15 || t == 16 || t == 24 || t == 31 || t == 32 || t == 40) begin
            checks++;
            if (frame_idx !== 2'((t / 8) % 4)) begin
               errors++; $display("FAIL anim_frame tick=%0d got %0d exp %0d", t, frame_idx, (t / 8) % 4);
            end
         end
      end
      checks++;
      if (pos_x !== 11'd100 || pos_y !== 11'd50) begin
         errors++; $display("FAIL anim_pos got (%0d,%0d) exp (100,50)", pos_x, pos_y);
      end
   endtask

   task automatic test_rst_mid();
      logic e;
      tick(1'b1, 1, 0);
      checks++;
      if (pos_x !== 11'd101 || frame_idx !== 2'd1) begin
         errors++; $display("FAIL premove got x=%0d f=%0d exp x=101 f=1", pos_x, frame_idx);
      end
      exp_q.delete();
      for (int k = 0; k <= 40; k++) begin
         if (k < 40) begin
            pix_x = 11'(96 + k);
            pix_y = 11'd50;
            if (k == 11 || k == 12) exp_q.push_back(1'b0);
            else if (k < 12) exp_q.push_back(exp_paint(96 + k, 50, 101, 50, 1, 0, 0));
            else exp_q.push_back(exp_paint(96 + k, 50, 100, 50, 0, 0, 0));
         end
         rst = (k == 12);
         cycle();
         if (k == 12) begin
            checks++;
            if (pos_x !== 11'd100 || pos_y !== 11'd50 || frame_idx !== 2'd0) begin
               errors++;
               $display("FAIL rst_mid_state got (%0d,%0d,f%0d) exp (100,50,f0)", pos_x, pos_y, frame_idx);
            end
         end
         if (k >= 1) begin
            e = exp_q.pop_front();
            checks++;
            if (paint !== e) begin
               errors++; $display("FAIL rst_mid_paint x=%0d got %0d exp %0d", 96 + k - 1, paint, e);
            end
         end
      end
      rst = 1'b0;
      m_cnt = 0;
      m_frame = 0;
   endtask

   task automatic test_move();
      int f_before;
      tick(1'b1, 3, -2);
      checks++;
      if (pos_x !== 11'd103 || pos_y !== 11'd48) begin
         errors++; $display("FAIL move_step got (%0d,%0d) exp (103,48)", pos_x, pos_y);
      end
      f_before = m_frame;
      for (int t = 0; t < 9; t++) tick(1'b0, 5, 5);
      checks++;
      if (pos_x !== 11'd103 || pos_y !== 11'd48 || frame_idx !== 2'(f_before)) begin
         errors++;
         $display("FAIL frozen got (%0d,%0d,f%0d) exp (103,48,f%0d)", pos_x, pos_y, frame_idx, f_before);
      end
      for (int t = 0; t < 71; t++) tick(1'b1, 7, 0);
      checks++;
      if (pos_x !== 11'd600) begin errors++; $display("FAIL move_600 got %0d exp 600", pos_x); end
      tick(1'b1, 6, 0);
      checks++;
      if (pos_x !== 11'd606) begin errors++; $display("FAIL move_606 got %0d exp 606", pos_x); end
      tick(1'b1, 7, 0);
      checks++;
      if (pos_x !== 11'd608) begin errors++; $display("FAIL clamp_xmax got %0d exp 608", pos_x); end
      tick(1'b1, 7, 0);
      checks++;
      if (pos_x !== 11'd608 || pos_y !== 11'd48) begin
         errors++; $display("FAIL clamp_hold got (%0d,%0d) exp (608,48)", pos_x, pos_y);
      end
      checks++;
      if (frame_idx !== 2'(m_frame)) begin
         errors++; $display("FAIL move_frame got %0d exp %0d", frame_idx, m_frame);
      end
      do_reset();
      for (int t = 0; t < 14; t++) tick(1'b1, -7, (t < 7) ? -7 : 0);
      checks++;
      if (pos_x !== 11'd2 || pos_y !== 11'd1) begin
         errors++; $display("FAIL move_2_1 got (%0d,%0d) exp (2,1)", pos_x, pos_y);
      end
      tick(1'b1, -5, -5);
      checks++;
      if (pos_x !== 11'd0 || pos_y !== 11'd0) begin
         errors++; $display("FAIL clamp_zero got (%0d,%0d) exp (0,0)", pos_x, pos_y);
      end
   endtask

   task automatic test_scale();
      int px[11] = '{0, 1, 2, 64, 63, 62, 0, 1, 0, 0, 0};
      int py[11] = '{0, 0, 0, 0, 2, 0, 0, 0, 2, 32, 31};
      int mr[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
      int ex[11] = '{1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1};
      for (int i = 0; i < 11; i++) begin
         b_pix_x = 11'(px[i]);
         b_pix_y = 11'(py[i]);
         b_mirror = mr[i][0];
         cycle();
         cycle();
         checks++;
         if (b_paint !== ex[i][0]) begin
            errors++;
            $display("FAIL scale_paint (%0d,%0d,m%0d) got %0d exp %0d", px[i], py[i], mr[i], b_paint, ex[i]);
         end
      end
      checks++;
      if (b_pos_x !== 11'd0 || b_pos_y !== 11'd0 || b_frame_idx !== 2'd0) begin
         errors++; $display("FAIL scale_state got (%0d,%0d,f%0d) exp (0,0,f0)", b_pos_x, b_pos_y, b_frame_idx);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_cnt = 0;
      m_frame = 0;
      rst = 1'b1;
      frame_tick = 1'b0;
      enable = 1'b0;
      dx = 4'sd0;
      dy = 4'sd0;
      mirror = 1'b0;
      pix_x = 11'd0;
      pix_y = 11'd0;
      b_tick = 1'b0;
      b_enable = 1'b0;
      b_dx = 4'sd0;
      b_dy = 4'sd0;
      b_mirror = 1'b0;
      b_pix_x = 11'd0;
      b_pix_y = 11'd0;

      test_reset();
      test_stream();
      test_animation();
      test_rst_mid();
      test_move();
      test_scale();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
